// File: rtl/wb_boot_copier_pkg.sv
// Shared definitions for the Wishbone boot copier.
//   state_e    : copier state machine encoding
//   WB_SEL_ALL : byte-select value for full 32-bit word transfers
//   idx_width  : width of the word counter for a given copy length in bytes
package wb_boot_copier_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_GAP,
    WR_REQ,
    WR_GAP,
    DONE,
    FAULT
  } state_e;

  localparam logic [3:0] WB_SEL_ALL = 4'hF;

  // One spare bit above what LENGTH/4 words strictly need.
  function automatic int idx_width(input int length_bytes);
    return $clog2(length_bytes / 4) + 1;
  endfunction

endpackage

// File: rtl/wb_boot_copier_if.sv
// Wishbone classic bus bundle used between the boot copier and the system bus.
//   master modport : cyc, stb, we, sel, adr, mosi out; miso, ack, err in
//   slave modport  : mirror image of master
module wb_boot_copier_if_dummy_unused_never; endmodule

interface wb_boot_copier_if #(
  parameter int ADDR_WIDTH = 32
) ();

  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [3:0]            sel;
  logic [ADDR_WIDTH-1:0] adr;
  logic [31:0]           mosi;
  logic [31:0]           miso;
  logic                  ack;
  logic                  err;

  modport master (
    output cyc, stb, we, sel, adr, mosi,
    input  miso, ack, err
  );

  modport slave (
    input  cyc, stb, we, sel, adr, mosi,
    output miso, ack, err
  );

endinterface

// File: rtl/wb_boot_copier.sv
// Wishbone classic master that copies LENGTH bytes, one 32-bit word at a time,
// from SRC_BASE (boot ROM) to DST_BASE (RAM). The CPU is held in reset by SoC
// glue until done rises.
//
// Ports:
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   start            : pulse; starts a copy from IDLE, DONE or FAULT
//   busy             : copy in progress
//   done             : last copy completed; held until next start/reset
//   fault            : last copy aborted; held until next start/reset
//   fault_adr        : byte address of the failing transfer
//   wb               : Wishbone master port (cyc/stb/we/sel/adr/mosi/miso/ack/err)
//
// Optional build macro WB_BOOT_COPIER_TIMEOUT_EN: abort a transfer with a fault
// when neither ack nor err arrives within TIMEOUT_CYCLES cycles. Without it the
// copier waits indefinitely.
module wb_boot_copier
  import wb_boot_copier_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 32,
  parameter logic [31:0] SRC_BASE       = 32'h0000_0000,
  parameter logic [31:0] DST_BASE       = 32'h1000_0000,
  parameter int          LENGTH         = 16384,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] fault_adr,
  wb_boot_copier_if.master      wb
);

  localparam int             WORDS    = LENGTH / 4;
  localparam int             IDX_W    = idx_width(LENGTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  // Elaboration-time parameter sanity checks.
  if ((SRC_BASE[1:0] != 2'b00) || (DST_BASE[1:0] != 2'b00)) begin : g_bad_align
    $error("wb_boot_copier: SRC_BASE and DST_BASE must be 4-byte aligned");
  end
  if ((LENGTH < 4) || ((LENGTH % 4) != 0)) begin : g_bad_length
    $error("wb_boot_copier: LENGTH must be a non-zero multiple of 4");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("wb_boot_copier: TIMEOUT_CYCLES must be at least 1");
  end

  // Byte address of word i within a region, truncated to the bus width.
  function automatic logic [ADDR_WIDTH-1:0] word_adr(input logic [31:0]      base,
                                                    input logic [IDX_W-1:0] i);
    return ADDR_WIDTH'(base) + ADDR_WIDTH'({i, 2'b00});
  endfunction

  state_e                state;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_nxt;
  logic [31:0]           data_q;
  logic                  cyc_r;
  logic                  stb_r;
  logic                  we_r;
  logic [ADDR_WIDTH-1:0] adr_r;
  logic [31:0]           mosi_r;
  logic                  timed_out;

  assign idx_nxt = idx + IDX_W'(1);

  assign wb.cyc  = cyc_r;
  assign wb.stb  = stb_r;
  assign wb.we   = we_r;
  assign wb.sel  = WB_SEL_ALL;
  assign wb.adr  = adr_r;
  assign wb.mosi = mosi_r;

`ifdef WB_BOOT_COPIER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wait_cnt;

  // wait_cnt counts completed cycles of the current request, so the check on
  // TIMEOUT_CYCLES-1 aborts on the edge ending the TIMEOUT_CYCLES-th cycle.
  assign timed_out = (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out = 1'b0;
`endif

  // Read data holding register; only meaningful once a read has acked.
  always_ff @(posedge sys_clk) begin
    if ((state == RD_REQ) && wb.ack && !wb.err) begin
      data_q <= wb.miso;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      fault_adr <= '0;
      cyc_r     <= 1'b0;
      stb_r     <= 1'b0;
      we_r      <= 1'b0;
      adr_r     <= '0;
      mosi_r    <= '0;
`ifdef WB_BOOT_COPIER_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
`ifdef WB_BOOT_COPIER_TIMEOUT_EN
      if ((state == RD_REQ) || (state == WR_REQ)) begin
        wait_cnt <= wait_cnt + TO_W'(1);
      end
`endif
      unique case (state)
        IDLE, DONE, FAULT: begin
          if (start) begin
            state <= RD_REQ;
            idx   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            fault <= 1'b0;
            cyc_r <= 1'b1;
            stb_r <= 1'b1;
            we_r  <= 1'b0;
            adr_r <= word_adr(SRC_BASE, '0);
`ifdef WB_BOOT_COPIER_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end

        RD_REQ, WR_REQ: begin
          // err has priority over a simultaneous ack.
          if (wb.err || (!wb.ack && timed_out)) begin
            state     <= FAULT;
            busy      <= 1'b0;
            fault     <= 1'b1;
            fault_adr <= adr_r;
            cyc_r     <= 1'b0;
            stb_r     <= 1'b0;
            we_r      <= 1'b0;
          end else if (wb.ack) begin
            state <= (state == RD_REQ) ? RD_GAP : WR_GAP;
            cyc_r <= 1'b0;
            stb_r <= 1'b0;
            we_r  <= 1'b0;
          end
        end

        // Slaves hold ack while stb stays high, so stb must drop for one
        // cycle between every pair of transfers.
        RD_GAP: begin
          state  <= WR_REQ;
          cyc_r  <= 1'b1;
          stb_r  <= 1'b1;
          we_r   <= 1'b1;
          adr_r  <= word_adr(DST_BASE, idx);
          mosi_r <= data_q;
`ifdef WB_BOOT_COPIER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end

        WR_GAP: begin
          if (idx == LAST_IDX) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= RD_REQ;
            idx   <= idx_nxt;
            cyc_r <= 1'b1;
            stb_r <= 1'b1;
            we_r  <= 1'b0;
            adr_r <= word_adr(SRC_BASE, idx_nxt);
`ifdef WB_BOOT_COPIER_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cyc_r <= 1'b0;
          stb_r <= 1'b0;
          we_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_boot_copier.sv
// Directed bench for wb_boot_copier with LENGTH=16: a four-word ROM/RAM slave
// model with selectable zero-wait or registered ack, error injection on one
// address, and a hang mode that never acknowledges.
module tb_wb_boot_copier;

  localparam logic [31:0] SRC = 32'h0000_0000;
  localparam logic [31:0] DST = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] fault_adr;

  always #5 clk = ~clk;

  wb_boot_copier_if #(.ADDR_WIDTH(32)) wb ();

  wb_boot_copier #(
    .ADDR_WIDTH     (32),
    .SRC_BASE       (SRC),
    .DST_BASE       (DST),
    .LENGTH         (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .sys_clk   (clk),
    .sys_rst   (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .fault_adr (fault_adr),
    .wb        (wb)
  );

  // ---------------- slave model ----------------
  logic [31:0] rom [4];
  logic [31:0] ram [4];
  logic        zw;
  logic        hang;
  logic        err_en;
  logic        err_we;
  logic [31:0] err_adr;
  logic        ack_q;
  logic        hit;

  assign hit     = wb.cyc && wb.stb && !hang;
  assign wb.ack  = hit && (zw ? 1'b1 : ack_q);
  assign wb.err  = hit && err_en && (wb.we == err_we) && (wb.adr == err_adr);
  assign wb.miso = rom[wb.adr[3:2]];

  always @(posedge clk) ack_q <= wb.cyc && wb.stb && !ack_q && !hang;

  // ---------------- bus monitor ----------------
  logic        mon_clr;
  logic        stb_prev;
  int          rises;
  int          rd_cnt;
  int          wr_cnt;
  int          bad_wr;
  logic        first_v;
  logic [31:0] first_adr;

  always @(posedge clk) begin
    if (mon_clr) begin
      rises    <= 0;
      rd_cnt   <= 0;
      wr_cnt   <= 0;
      bad_wr   <= 0;
      stb_prev <= 1'b0;
      first_v  <= 1'b0;
      for (int k = 0; k < 4; k++) ram[k] <= 32'h0;
    end else begin
      stb_prev <= wb.stb;
      if (wb.stb && !stb_prev) begin
        rises <= rises + 1;
        if (!first_v) begin
          first_v   <= 1'b1;
          first_adr <= wb.adr;
        end
      end
      if (hit && wb.ack && !wb.err) begin
        if (wb.we) begin
          wr_cnt <= wr_cnt + 1;
          if (wb.adr[31:4] == DST[31:4]) ram[wb.adr[3:2]] <= wb.mosi;
          else bad_wr <= bad_wr + 1;
        end else begin
          rd_cnt <= rd_cnt + 1;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_clear();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Cycles from the start edge until done or fault (bounded).
  task automatic wait_end(output int n);
    n = 0;
    while (!(done || fault) && n < 500) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_ram(input string tag, input int n_ok);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_ram%0d", tag, k), ram[k], (k < n_ok) ? rom[k] : 32'h0);
    end
  endtask

  typedef struct {
    string       name;
    logic        zw;
    logic        err_en;
    logic        err_we;
    logic [31:0] err_adr;
    int          cycles;
    logic        done;
    logic        fault;
    logic [31:0] fadr;
    int          rd;
    int          wr;
    int          rises;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int n;
    int rises_before;

    rom[0] = 32'h1122_3344;
    rom[1] = 32'h5566_7788;
    rom[2] = 32'h99AA_BBCC;
    rom[3] = 32'hDDEE_FF00;

    vecs[0] = '{"zero_wait",  1'b1, 1'b0, 1'b0, 32'h0,          16, 1'b1, 1'b0, 32'h0,          4, 4, 8};
    vecs[1] = '{"reg_ack",    1'b0, 1'b0, 1'b0, 32'h0,          24, 1'b1, 1'b0, 32'h0,          4, 4, 8};
    vecs[2] = '{"wr_err",     1'b1, 1'b1, 1'b1, DST + 32'h8,    11, 1'b0, 1'b1, DST + 32'h8,    3, 2, 6};
    vecs[3] = '{"rd_err",     1'b0, 1'b1, 1'b0, SRC + 32'h4,     7, 1'b0, 1'b1, SRC + 32'h4,    1, 1, 3};

    rst     = 1'b1;
    start   = 1'b0;
    zw      = 1'b1;
    hang    = 1'b0;
    err_en  = 1'b0;
    err_we  = 1'b0;
    err_adr = 32'h0;
    mon_clr = 1'b1;
    tick();
    tick();

    chk("rst_busy",  {31'h0, busy},  32'h0);
    chk("rst_done",  {31'h0, done},  32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    chk("rst_cyc",   {31'h0, wb.cyc}, 32'h0);
    chk("rst_stb",   {31'h0, wb.stb}, 32'h0);
    chk("rst_we",    {31'h0, wb.we},  32'h0);
    chk("rst_adr",   wb.adr,    32'h0);
    chk("rst_mosi",  wb.mosi,   32'h0);
    chk("rst_fadr",  fault_adr, 32'h0);
    chk("rst_sel",   {28'h0, wb.sel}, 32'hF);

    rst     = 1'b0;
    mon_clr = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      zw      = vecs[i].zw;
      err_en  = vecs[i].err_en;
      err_we  = vecs[i].err_we;
      err_adr = vecs[i].err_adr;
      mon_clear();
      start_pulse();
      wait_end(n);
      chk({vecs[i].name, "_cycles"}, n, vecs[i].cycles);
      chk({vecs[i].name, "_done"},   {31'h0, done},  {31'h0, vecs[i].done});
      chk({vecs[i].name, "_fault"},  {31'h0, fault}, {31'h0, vecs[i].fault});
      chk({vecs[i].name, "_busy"},   {31'h0, busy},  32'h0);
      if (vecs[i].fault) chk({vecs[i].name, "_fadr"}, fault_adr, vecs[i].fadr);
      tick();
      tick();
      tick();
      chk({vecs[i].name, "_rd"},    rd_cnt, vecs[i].rd);
      chk({vecs[i].name, "_wr"},    wr_cnt, vecs[i].wr);
      chk({vecs[i].name, "_rises"}, rises,  vecs[i].rises);
      chk({vecs[i].name, "_badwr"}, bad_wr, 0);
      chk({vecs[i].name, "_cyc_idle"}, {31'h0, wb.cyc}, 32'h0);
      chk_ram(vecs[i].name, vecs[i].wr);
    end
    err_en = 1'b0;

    // Reset during the write of word 1, then a clean recopy from word 0.
    zw = 1'b0;
    mon_clear();
    start_pulse();
    n = 0;
    while (!(wb.stb && wb.we && wb.adr == DST + 32'h4) && n < 100) begin
      tick();
      n++;
    end
    chk("midrst_reach_wr1", {31'h0, n < 100}, 32'h1);
    rst = 1'b1;
    tick();
    chk("midrst_cyc",   {31'h0, wb.cyc}, 32'h0);
    chk("midrst_stb",   {31'h0, wb.stb}, 32'h0);
    chk("midrst_busy",  {31'h0, busy},  32'h0);
    chk("midrst_done",  {31'h0, done},  32'h0);
    chk("midrst_fault", {31'h0, fault}, 32'h0);
    rst = 1'b0;
    zw  = 1'b1;
    mon_clear();
    start_pulse();
    wait_end(n);
    chk("recopy_cycles", n, 16);
    chk("recopy_done", {31'h0, done}, 32'h1);
    chk("recopy_first_adr", first_adr, SRC);
    chk_ram("recopy", 4);

    // start while busy is ignored; start after done repeats the copy.
    mon_clear();
    start_pulse();
    tick();
    tick();
    tick();
    start_pulse();
    wait_end(n);
    chk("busy_start_cycles", n, 12);
    chk("busy_start_rises", rises, 8);
    chk("busy_start_done", {31'h0, done}, 32'h1);
    rises_before = rises;
    start_pulse();
    chk("restart_done_clr", {31'h0, done}, 32'h0);
    chk("restart_busy",     {31'h0, busy}, 32'h1);
    wait_end(n);
    tick();
    chk("restart_cycles", n, 16);
    chk("restart_rises", rises - rises_before, 8);
    chk("restart_wr", wr_cnt, 8);
    chk("restart_done", {31'h0, done}, 32'h1);
    chk_ram("restart", 4);

`ifdef WB_BOOT_COPIER_TIMEOUT_EN
    hang = 1'b1;
    mon_clear();
    start_pulse();
    wait_end(n);
    chk("to_cycles", n, 8);
    chk("to_fault", {31'h0, fault}, 32'h1);
    chk("to_done",  {31'h0, done},  32'h0);
    chk("to_fadr",  fault_adr, SRC);
    chk("to_cyc",   {31'h0, wb.cyc}, 32'h0);
    tick();
    chk("to_rises", rises, 1);
    hang = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_boot_copier.md
Name: wb_boot_copier

Overview:
- Wishbone classic master that copies a word-aligned image from a source region (boot ROM) to a destination region (RAM), one word at a time.
- It sits on the system bus ahead of the CPU. SoC glue holds the CPU in reset until `done` rises.
- It is the initiator counterpart of the bus's slave cores. It must tolerate any slave ack latency, including the ROM's one-cycle registered ack.

Parameters:
- ADDR_WIDTH, 32, width of wb_adr (byte address).
- SRC_BASE, 32'h0000_0000, byte address of first source word; must be 4-byte aligned.
- DST_BASE, 32'h1000_0000, byte address of first destination word; must be 4-byte aligned.
- LENGTH, 16384, bytes to copy; a multiple of 4, minimum 4.
- TIMEOUT_CYCLES, 255, max cycles a single transfer waits for ack/err; used only with the optional feature.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a copy when in IDLE, DONE or FAULT; ignored otherwise.
- busy  out  1  high while a copy is in progress.
- done  out  1  high after a successful copy, until the next start or reset.
- fault  out  1  high after an aborted copy, until the next start or reset.
- fault_adr  out  ADDR_WIDTH  byte address of the transfer that failed.
- wb_cyc  out  1  bus cycle.
- wb_stb  out  1  strobe.
- wb_we  out  1  write enable.
- wb_sel  out  4  byte selects; always 4'hF.
- wb_adr  out  ADDR_WIDTH  byte address.
- wb_mosi  out  32  write data.
- wb_miso  in  32  read data.
- wb_ack  in  1  slave acknowledge.
- wb_err  in  1  slave error.

Behaviour:
- Reset:
  - State IDLE.
  - busy, done, fault, wb_cyc, wb_stb and wb_we are 0.
  - wb_adr, wb_mosi and fault_adr are 0; wb_sel is 4'hF.
  - Reset mid-transfer drops cyc/stb on the next edge. There is no resume.
- Word counter idx counts 0..LENGTH/4-1 and is $clog2(LENGTH/4)+1 bits wide.
  - Read address = SRC_BASE + {idx,2'b00}; write address = DST_BASE + {idx,2'b00}.
  - Addresses are truncated to ADDR_WIDTH.
- State machine: IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP, DONE, FAULT.
  - IDLE/DONE/FAULT + start: clear done, fault and idx; set busy; go to RD_REQ.
  - RD_REQ: cyc=stb=1, we=0, adr=read address.
    - On ack: latch wb_miso into the data register unmodified (no byte swapping), drop cyc/stb, go to RD_GAP.
    - On err: go to FAULT.
  - RD_GAP: cyc=stb=0 for exactly one cycle, then go to WR_REQ. The idle cycle is mandatory: slaves hold ack while stb stays high.
  - WR_REQ: cyc=stb=1, we=1, adr=write address, mosi=data register.
    - On ack: drop cyc/stb, go to WR_GAP.
    - On err: go to FAULT.
  - WR_GAP: one idle cycle.
    - If idx==LENGTH/4-1, go to DONE.
    - Otherwise increment idx and go to RD_REQ.
  - DONE: busy=0, done=1.
  - FAULT: busy=0, fault=1, fault_adr = the address of the failing transfer, cyc/stb=0.
- ack and err together: err wins.
- ack/err sampled outside RD_REQ/WR_REQ: ignored.
- Minimum throughput: 4 cycles per word with a zero-wait slave. A ROM with registered ack gives 6 cycles per word.
- start asserted while busy: ignored.

Optional Feature:
- Macro: WB_BOOT_COPIER_TIMEOUT_EN.
- When defined: a per-transfer wait counter is cleared on entry to RD_REQ/WR_REQ. If TIMEOUT_CYCLES cycles pass without ack or err, the block goes to FAULT with fault_adr = the current address, and cyc/stb drop.
- When undefined: the block waits indefinitely and has no counter logic.

Decomposition:
- Shared package holds:
  - state enum: IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP, DONE, FAULT;
  - WB_SEL_ALL = 4'hF;
  - the word-index width helper function.
- The Wishbone port list uses the codebase's master-side port macro on the wb prefix.
- No sub-module. The timeout counter is inline under the macro.

Test Plan:
- LENGTH=16, ROM model preloaded with 0x11223344, 0x55667788, 0x99AABBCC, 0xDDEEFF00; start pulse -> RAM model at DST_BASE holds the same four words in order; done=1, busy=0; 4 reads and 4 writes, each separated by at least one cycle with stb=0.
- Zero-wait slave (ack the same cycle as stb) -> exactly 4 cycles per word; idx reaches 3; done rises 16 cycles after leaving IDLE.
- Slave asserts err on the write to DST_BASE+8 -> fault=1, fault_adr=DST_BASE+8, done=0; no further bus cycles.
- sys_rst asserted during the WR_REQ of word 1 -> next edge cyc=stb=0 and all status outputs 0; a following start recopies from idx 0.
- start pulsed while busy, then again after done -> first pulse ignored; second pulse clears done and repeats the copy.
- With WB_BOOT_COPIER_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never acks -> fault rises 8 cycles after stb on SRC_BASE; fault_adr=SRC_BASE.
